data_memory_responder: RTL and testbench
========================================

# data_memory_responder

Data-memory responder answering the load/store requests the memory-access stage issues each cycle. Holds a word-organised RAM with byte lanes and a memory-mapped host-communication (HC) register. Returns load data with sign or zero extension. Mirrors every committed write onto debug outputs for the debug path.

## Interface
Parameters:
- DEPTH_WORDS, 4096: RAM depth in 32-bit words; valid RAM byte range is [0, DEPTH_WORDS*4).
- HC_ADDR, 32'h0000_8000: byte address of the HC register; must lie outside the RAM range.

Ports (reset is asynchronous and active-high; one clock):
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  request rejected; valid only with rsp_valid.
- hc_out  out  32  current HC register value.
- dbg_waddr  out  32  byte address of the last committed write.
- dbg_wdata  out  32  lane-placed write data of the last committed write.
- dbg_wenable  out  4  byte enables; nonzero for exactly one cycle per committed write.

## Operation
- FSM states: IDLE, READ, RESP. req_ready = (state == IDLE).
- A request is accepted on a rising edge with req_valid && req_ready. Inputs are sampled only at acceptance.
- Error classification at acceptance:
  - size 11 is an error.
  - Half with addr[0]=1 is an error.
  - Word with addr[1:0]≠0 is an error.
  - An address outside the RAM range and ≠ HC_ADDR is an error.
  - An HC_ADDR access with size ≠ word is an error.
- Error handling: no write occurs, IDLE→RESP, and the response carries rsp_err=1 and rsp_rdata=0.
- Store lane placement:
  - Byte: wdata[7:0] replicated to all four lanes, enable = 4'b0001 << addr[1:0].
  - Half: wdata[15:0] replicated to both halves, enable = 4'b0011 << addr[1:0].
  - Word: enable 4'b1111.
- Store commit:
  - The RAM word addr[31:2] is written at the accepting edge, updating only the enabled lanes.
  - A store to HC_ADDR loads hc_out instead of the RAM.
  - The dbg_* outputs register the address, placed data and enable at the same edge. dbg_wenable returns to 0 on the next edge unless another write commits.
  - FSM: IDLE→RESP.
- Load:
  - Accepting edge: a RAM read of word addr[31:2] is issued (synchronous read), and addr[1:0], size and unsigned are latched. FSM: IDLE→READ.
  - READ edge: the word is shifted right by 8*addr[1:0], truncated to the request size, then extended, and the result is registered. FSM: READ→RESP.
  - A load from HC_ADDR returns hc_out as sampled in READ.
- RESP: rsp_valid=1 for exactly one cycle, then RESP→IDLE. There is no response backpressure; the consumer must take the pulse.
- RAM contents are not initialised or cleared by reset.

## Timing
- Accept at edge N:
  - Store or error: rsp_valid high in cycle N+1.
  - Load: rsp_valid high in cycle N+2.
- Throughput: one store per 2 cycles, one load per 3 cycles. req_ready is low in READ and RESP.
- A read-after-write to the same word returns the written data, because the write commits before READ samples the RAM.
- Reset values: state IDLE, req_ready 1 once rst deasserts, rsp_valid 0, rsp_rdata 0, rsp_err 0, hc_out 0, dbg_waddr 0, dbg_wdata 0, dbg_wenable 0.
- Reset asserted mid-operation (in READ or RESP) aborts the transaction. No response is produced for it. A store already committed before reset stays in the RAM.
- req_valid held high while req_ready is low has no effect. The request is accepted on the next cycle in IDLE.

## Test plan
- Word store then load: store 0xDEADBEEF at 0x10. Response after 1 cycle with err 0, dbg_wenable 4'b1111 for 1 cycle. Load word from 0x10 returns 0xDEADBEEF 2 cycles after accept.
- Byte and half extension (word 0x10 = 0xDEADBEEF):
  - Load byte from 0x13, signed → 0xFFFFFFDE.
  - Load byte from 0x13, unsigned → 0x000000DE.
  - Load half from 0x12, signed → 0xFFFFDEAD.
  - Load half from 0x10, unsigned → 0x0000BEEF.
- Partial store: store byte 0x55 at 0x11 into 0xDEADBEEF. dbg_wenable = 4'b0010 and dbg_wdata = 0x55555555. A following word load returns 0xDEAD55EF.
- Errors: each of the following responds after 1 cycle with rsp_err 1, rsp_rdata 0, and RAM and hc_out unchanged:
  - half load from 0x21
  - word store to 0x22
  - size 11
  - word load from DEPTH_WORDS*4
  - byte store to HC_ADDR
- HC register: word store 0x00000001 to HC_ADDR → hc_out = 1 after the accepting edge. A word load from HC_ADDR returns 0x00000001.
- Reset mid-load: accept a load, assert rst during READ. Required: rsp_valid never pulses, all outputs return to reset values, and req_ready is 1 after release. A store committed before reset is still readable.

Source files
------------

// File: rtl/data_memory_responder.sv
// ----------------------------------------------------------------------------
// data_memory_responder
//
// Answers the load/store requests issued by the memory-access stage. Holds a
// word-organised RAM with byte lanes plus a memory-mapped host-communication
// (HC) register. Loads return sign- or zero-extended data; every committed
// write is mirrored onto the dbg_* outputs for one cycle.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req_valid       request present
//   req_ready       high only in IDLE; a request is taken on valid && ready
//   req_we          1 = store, 0 = load
//   req_size        00 byte, 01 half, 10 word, 11 reserved (error)
//   req_unsigned    zero-extend loads when 1, sign-extend when 0
//   req_addr        byte address
//   req_wdata       store data, right-aligned
//   rsp_valid       one-cycle response pulse (no backpressure)
//   rsp_rdata       extended load data; 0 for stores and errors
//   rsp_err         request rejected; meaningful only with rsp_valid
//   hc_out          current HC register value
//   dbg_waddr       byte address of the last committed write
//   dbg_wdata       lane-placed data of the last committed write
//   dbg_wenable     byte enables, nonzero for one cycle per committed write
// ----------------------------------------------------------------------------
module data_memory_responder #(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] HC_ADDR     = 32'h0000_8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] hc_out,
    output logic [31:0] dbg_waddr,
    output logic [31:0] dbg_wdata,
    output logic [3:0]  dbg_wenable
);

    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {IDLE, READ, RESP} stateT;

    stateT state;

    // Load context captured at acceptance, consumed on the READ edge.
    logic [1:0]  loadOffP1;
    logic [1:0]  loadSizeP1;
    logic        loadUnsP1;
    logic        loadHcP1;
    logic [31:0] ramRdataP1;

    logic [31:0] mem [0:DEPTH_WORDS-1];

    logic          accept;
    logic          isHc;
    logic          reqErr;
    logic          ramWe;
    logic          ramRe;
    logic [AW-1:0] wordIdx;
    logic [31:0]   placedData;
    logic [3:0]    laneEn;

    // Rejection rules: reserved size, misalignment, unmapped address, and
    // anything but a full-word access to the HC register.
    function automatic logic classifyErr(input logic [1:0] size, input logic [31:0] addr);
        logic err;
        logic hc;
        hc  = (addr == HC_ADDR);
        err = 1'b0;
        case (size)
            2'b11:   err = 1'b1;
            2'b01:   if (addr[0]) err = 1'b1;
            2'b10:   if (addr[1:0] != 2'b00) err = 1'b1;
            default: err = 1'b0;
        endcase
        if (!(addr < RAM_BYTES) && !hc) err = 1'b1;
        if (hc && size != 2'b10) err = 1'b1;
        return err;
    endfunction

    // Replicate narrow store data across lanes so the enables alone pick
    // the destination bytes.
    function automatic logic [31:0] placeData(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [3:0] laneEnable(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] extendLoad(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] size, input logic uns);
        logic [31:0] s;
        s = word >> {off, 3'b000};
        case (size)
            2'b00:   return uns ? {24'h0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
            2'b01:   return uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            default: return s;
        endcase
    endfunction

    assign req_ready  = (state == IDLE);
    assign accept     = req_valid && req_ready && !rst;
    assign isHc       = (req_addr == HC_ADDR);
    assign reqErr     = classifyErr(req_size, req_addr);
    assign wordIdx    = req_addr[AW+1:2];
    assign placedData = placeData(req_size, req_wdata);
    assign laneEn     = laneEnable(req_size, req_addr[1:0]);
    // A non-error, non-HC access is guaranteed to be inside the RAM range.
    assign ramWe      = accept && req_we && !reqErr && !isHc;
    assign ramRe      = accept && !req_we && !reqErr && !isHc;

    // RAM: byte-lane writes and synchronous read; never reset, so a store
    // committed before a reset survives it.
    always_ff @(posedge clk) begin
        if (ramWe) begin
            for (int i = 0; i < 4; i++) begin
                if (laneEn[i]) mem[wordIdx][8*i +: 8] <= placedData[8*i +: 8];
            end
        end
        if (ramRe) ramRdataP1 <= mem[wordIdx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 32'h0;
            rsp_err     <= 1'b0;
            hc_out      <= 32'h0;
            dbg_waddr   <= 32'h0;
            dbg_wdata   <= 32'h0;
            dbg_wenable <= 4'h0;
            loadOffP1   <= 2'b00;
            loadSizeP1  <= 2'b00;
            loadUnsP1   <= 1'b0;
            loadHcP1    <= 1'b0;
        end else begin
            dbg_wenable <= 4'h0;
            case (state)
                // Stage 0: accept, classify, commit stores or issue RAM read
                IDLE: begin
                    rsp_valid <= 1'b0;
                    if (accept) begin
                        if (reqErr) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0;
                        end else if (req_we) begin
                            state       <= RESP;
                            rsp_valid   <= 1'b1;
                            rsp_err     <= 1'b0;
                            rsp_rdata   <= 32'h0;
                            dbg_waddr   <= req_addr;
                            dbg_wdata   <= placedData;
                            dbg_wenable <= laneEn;
                            if (isHc) hc_out <= placedData;
                        end else begin
                            state      <= READ;
                            loadOffP1  <= req_addr[1:0];
                            loadSizeP1 <= req_size;
                            loadUnsP1  <= req_unsigned;
                            loadHcP1   <= isHc;
                        end
                    end
                end
                // Stage 1: align, truncate and extend the read word
                READ: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= extendLoad(loadHcP1 ? hc_out : ramRdataP1,
                                            loadOffP1, loadSizeP1, loadUnsP1);
                end
                // Stage 2: response pulse is visible this cycle
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;

    localparam int          DEPTH_WORDS = 4096;
    localparam logic [31:0] HC_ADDR     = 32'h0000_8000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] hc_out;
    logic [31:0] dbg_waddr;
    logic [31:0] dbg_wdata;
    logic [3:0]  dbg_wenable;

    int checks = 0;
    int errors = 0;

    // dbg_* snapshot taken just after the accepting edge
    logic [31:0] lastWaddr;
    logic [31:0] lastWdata;
    logic [3:0]  lastWen;

    data_memory_responder #(.DEPTH_WORDS(DEPTH_WORDS), .HC_ADDR(HC_ADDR)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .hc_out(hc_out), .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata),
        .dbg_wenable(dbg_wenable)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // One full transaction with fixed latency: store/error responds one
    // cycle after acceptance, load two cycles after.
    task automatic access(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic expErr, input logic [31:0] expData);
        @(negedge clk);
        chk({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lastWaddr = dbg_waddr;
        lastWdata = dbg_wdata;
        lastWen   = dbg_wenable;
        if (!(we || expErr)) begin
            chk({tag, "_early"}, {31'h0, rsp_valid}, 32'h0);
            @(posedge clk);
            #1;
        end
        chk({tag, "_vld"}, {31'h0, rsp_valid}, 32'h1);
        chk({tag, "_err"}, {31'h0, rsp_err}, {31'h0, expErr});
        chk({tag, "_data"}, rsp_rdata, expData);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, {31'h0, rsp_valid}, 32'h0);
        chk({tag, "_wenclr"}, {28'h0, dbg_wenable}, 32'h0);
    endtask

    task automatic checkResetOutputs(input string tag);
        chk({tag, "_vld"},   {31'h0, rsp_valid}, 32'h0);
        chk({tag, "_rdata"}, rsp_rdata, 32'h0);
        chk({tag, "_err"},   {31'h0, rsp_err}, 32'h0);
        chk({tag, "_hc"},    hc_out, 32'h0);
        chk({tag, "_waddr"}, dbg_waddr, 32'h0);
        chk({tag, "_wdata"}, dbg_wdata, 32'h0);
        chk({tag, "_wen"},   {28'h0, dbg_wenable}, 32'h0);
    endtask

    initial begin
        logic sawVld;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("rst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready", {31'h0, req_ready}, 32'h1);

        // Word store then load
        access("st_w", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        chk("st_w_wen",   {28'h0, lastWen}, 32'hF);
        chk("st_w_waddr", lastWaddr, 32'h10);
        chk("st_w_wdata", lastWdata, 32'hDEADBEEF);
        access("ld_w", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

        // Extension
        access("ld_b13s", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, 32'hFFFFFFDE);
        access("ld_b13u", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, 32'h000000DE);
        access("ld_h12s", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, 32'hFFFFDEAD);
        access("ld_h10u", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b0, 32'h0000BEEF);
        access("ld_b10s", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0, 32'hFFFFFFEF);

        // Partial byte store
        access("st_b11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055, 1'b0, 32'h0);
        chk("st_b11_wen",   {28'h0, lastWen}, 32'h2);
        chk("st_b11_wdata", lastWdata, 32'h55555555);
        chk("st_b11_waddr", lastWaddr, 32'h11);
        access("ld_after_b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD55EF);

        // Half store into upper half
        access("st_w14", 1'b1, 2'b10, 1'b0, 32'h14, 32'h00000000, 1'b0, 32'h0);
        access("st_h16", 1'b1, 2'b01, 1'b0, 32'h16, 32'h1234A5C3, 1'b0, 32'h0);
        chk("st_h16_wen",   {28'h0, lastWen}, 32'hC);
        chk("st_h16_wdata", lastWdata, 32'hA5C3A5C3);
        access("ld_after_h", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b0, 32'hA5C30000);

        // Errors: no write, rdata 0
        access("e_h21",  1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 1'b1, 32'h0);
        access("e_w22",  1'b1, 2'b10, 1'b0, 32'h22, 32'h11111111, 1'b1, 32'h0);
        chk("e_w22_wen", {28'h0, lastWen}, 32'h0);
        access("e_w12",  1'b1, 2'b10, 1'b0, 32'h12, 32'h22222222, 1'b1, 32'h0);
        chk("e_w12_wen", {28'h0, lastWen}, 32'h0);
        access("e_sz3",  1'b1, 2'b11, 1'b0, 32'h10, 32'h33333333, 1'b1, 32'h0);
        chk("e_sz3_wen", {28'h0, lastWen}, 32'h0);
        access("e_oor",  1'b0, 2'b10, 1'b0, 32'(DEPTH_WORDS * 4), 32'h0, 1'b1, 32'h0);
        access("e_hcb",  1'b1, 2'b00, 1'b0, HC_ADDR, 32'h000000FF, 1'b1, 32'h0);
        chk("e_hcb_wen", {28'h0, lastWen}, 32'h0);
        chk("e_hcb_hc",  hc_out, 32'h0);
        access("ld_unchanged", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD55EF);

        // HC register
        access("st_hc", 1'b1, 2'b10, 1'b0, HC_ADDR, 32'h00000001, 1'b0, 32'h0);
        chk("st_hc_wen",   {28'h0, lastWen}, 32'hF);
        chk("st_hc_waddr", lastWaddr, HC_ADDR);
        chk("st_hc_val",   hc_out, 32'h1);
        access("ld_hc", 1'b0, 2'b10, 1'b0, HC_ADDR, 32'h0, 1'b0, 32'h00000001);

        // Reset during READ aborts the load
        access("st_w40", 1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678, 1'b0, 32'h0);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h40;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst       = 1'b1;
        sawVld    = 1'b0;
        #1;
        checkResetOutputs("mid_rst");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) sawVld = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            if (rsp_valid) sawVld = 1'b1;
            @(posedge clk);
        end
        #1;
        if (rsp_valid) sawVld = 1'b1;
        chk("mid_rst_novld", {31'h0, sawVld}, 32'h0);
        chk("mid_rst_ready", {31'h0, req_ready}, 32'h1);
        access("ld_w40_post", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0, 32'h12345678);
        access("ld_w10_post", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD55EF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
